instr_fetch: RTL and testbench

//  Instruction fetch stage directly upstream of the instruction decoder. Holds the PC,

---
 rtl/instr_fetch.sv | 152 +++++++++++++++
 tb/tb_instr_fetch.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, req/gnt/rvalid fetch bus, in-order prefetch FIFO and redirect flush.
// Define IFETCH_ALIGN_CHECK_EN to fault on misaligned redirect targets instead of silently aligning them.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_data_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_fault_o
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;
    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_FLUSH} state_t;

    localparam cnt_t DEPTH_C = cnt_t'(FIFO_DEPTH);

    state_t      state, state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] resp_pc;
    logic [31:0] redirect_target;
    cnt_t        outstanding, outstanding_nxt;
    cnt_t        drop, drop_nxt;
    cnt_t        fifo_count;
    ptr_t        rd_ptr, wr_ptr;
    logic [31:0] fifo_data [FIFO_DEPTH];
    logic [31:0] fifo_pc   [FIFO_DEPTH];
    logic [CW:0] inflight;
    logic        fault;
    logic        issue, rsp, push, pop;

    assign redirect_target = redirect_pc_i & 32'hFFFF_FFFC;

    // Every outstanding request owns a FIFO slot, so a returning word can always be pushed.
    assign inflight    = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem_req_o  = (state != ST_IDLE) && !fault && (inflight < {1'b0, DEPTH_C});
    assign imem_addr_o = fetch_pc;
    assign issue       = imem_req_o && imem_gnt_i;

    // A response with nothing outstanding belongs to a request issued before a reset.
    assign rsp  = imem_rvalid_i && (outstanding != '0);
    assign push = rsp && (drop == '0) && !redirect_i;
    assign pop  = instr_valid_o && instr_ready_i;

    assign instr_valid_o = (fifo_count != '0);
    assign instr_data_o  = fifo_data[rd_ptr];
    assign instr_pc_o    = fifo_pc[rd_ptr];
    assign instr_fault_o = fault;

    // On redirect, everything still on the bus (including a grant this cycle) becomes stale.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        outstanding_nxt = outstanding + cnt_t'(issue) - cnt_t'(rsp);
        drop_nxt        = drop;
        if (redirect_i) begin
            drop_nxt = outstanding_nxt;
        end else if (rsp && (drop != '0)) begin
            drop_nxt = drop - cnt_t'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  state_nxt = ST_FETCH;
            ST_FETCH: if (redirect_i && (drop_nxt != '0)) state_nxt = ST_FLUSH;
            ST_FLUSH: if (drop_nxt == '0) state_nxt = ST_FETCH;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            // NOTE: storage is reset only because it is two entries and the head must read zero.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else begin
            outstanding <= outstanding_nxt;
            drop        <= drop_nxt;
            if (redirect_i) begin
                fetch_pc   <= redirect_target;
                resp_pc    <= redirect_target;
                fifo_count <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                // Surviving responses are contiguous, so their PC is just a running counter.
                if (push) begin
                    fifo_data[wr_ptr] <= imem_rdata_i;
                    fifo_pc[wr_ptr]   <= resp_pc;
                    resp_pc           <= resp_pc + 32'd4;
                    wr_ptr            <= wr_ptr + ptr_t'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + ptr_t'(1);
                end
                fifo_count <= fifo_count + cnt_t'(push) - cnt_t'(pop);
            end
        end
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    logic redirect_fault;
    assign redirect_fault = (redirect_pc_i[1:0] != 2'b00);

    // Fault holds off issue until a later aligned redirect clears it.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fault <= 1'b0;
        end else if (redirect_i) begin
            fault <= redirect_fault;
        end
    end
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a bus model answers grants in order and a scoreboard
// predicts every word reaching the decoder, flushing predictions on redirect.
`timescale 1ns/1ps
module tb_instr_fetch;
    localparam int          FIFO_DEPTH = 2;
    localparam logic [31:0] WRAP_PC    = 32'hFFFF_FFFC;
`ifdef IFETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        instr_valid, instr_ready, instr_fault;
    logic [31:0] instr_data, instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        w_req, w_valid, w_fault;
    logic [31:0] w_addr, w_data, w_pc;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt),
        .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
        .instr_valid_o(instr_valid), .instr_data_o(instr_data), .instr_pc_o(instr_pc),
        .instr_ready_i(instr_ready), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .instr_fault_o(instr_fault)
    );

    // Second instance shares all inputs; only its wrapping fetch address is inspected.
    instr_fetch #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut_wrap (
        .clk_i(clk), .rstn_i(rstn),
        .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(imem_gnt),
        .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
        .instr_valid_o(w_valid), .instr_data_o(w_data), .instr_pc_o(w_pc),
        .instr_ready_i(instr_ready), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .instr_fault_o(w_fault)
    );

    typedef struct { logic [31:0] addr; bit stale; } req_t;
    typedef struct { logic [31:0] data; logic [31:0] pc; } item_t;

    req_t        pending[$];
    item_t       exp_q[$];
    logic [31:0] popped[$];
    logic [31:0] granted[$];
    logic [31:0] exp_addr;
    logic [31:0] redir_addr;
    bit          gnt_en, rsp_en, ready_q, redir_req, redir_on_both, both_hit, faulted;
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] pop_at(input int k);
        return (popped.size() > k) ? popped[k] : 32'hDEAD_DEAD;
    endfunction

    // One bus cycle: check DUT outputs against the model, then drive inputs for the next edge.
    task automatic tick();
        req_t  r;
        item_t it;
        bit    do_rsp, grant, do_redir;
        r = '{32'h0, 1'b0};
        @(negedge clk);
        do_rsp = rsp_en && (pending.size() > 0);
        grant  = imem_req && gnt_en;
        do_redir = redir_req;
        if (redir_on_both && do_rsp && grant) begin
            do_redir      = 1'b1;
            both_hit      = 1'b1;
            redir_on_both = 1'b0;
        end

        n_checks++;
        if (imem_req !== (!faulted && (exp_q.size() + pending.size() < FIFO_DEPTH))) begin
            n_errors++;
            $display("FAIL req_rule: imem_req_o=%b with fifo=%0d outstanding=%0d fault=%b",
                     imem_req, exp_q.size(), pending.size(), faulted);
        end
        n_checks++;
        if (instr_valid !== (exp_q.size() != 0)) begin
            n_errors++;
            $display("FAIL valid: instr_valid_o=%b expected %b", instr_valid, exp_q.size() != 0);
        end else if (exp_q.size() != 0) begin
            n_checks++;
            if ({instr_data, instr_pc} !== {exp_q[0].data, exp_q[0].pc}) begin
                n_errors++;
                $display("FAIL head: data=%h pc=%h expected data=%h pc=%h",
                         instr_data, instr_pc, exp_q[0].data, exp_q[0].pc);
            end
        end

        imem_gnt    = gnt_en;
        instr_ready = ready_q;
        redirect    = do_redir;
        redirect_pc = redir_addr;
        if (do_rsp) begin
            r           = pending.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(r.addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom();
        end

        if (instr_valid && ready_q && exp_q.size() != 0) begin
            it = exp_q.pop_front();
            popped.push_back(it.pc);
        end
        if (grant) begin
            n_checks++;
            if (imem_addr !== exp_addr) begin
                n_errors++;
                $display("FAIL fetch_addr: imem_addr_o=%h expected %h", imem_addr, exp_addr);
            end
            granted.push_back(imem_addr);
            exp_addr = exp_addr + 32'd4;
        end

        if (do_redir) begin
            exp_q.delete();
            foreach (pending[i]) pending[i].stale = 1'b1;
            if (grant) pending.push_back('{imem_addr, 1'b1});
            exp_addr = redir_addr & 32'hFFFF_FFFC;
            faulted  = ALIGN_EN && (redir_addr[1:0] != 2'b00);
        end else begin
            if (do_rsp && !r.stale) exp_q.push_back('{mem_word(r.addr), r.addr});
            if (grant) pending.push_back('{imem_addr, 1'b0});
        end
        redir_req = 1'b0;
    endtask

    // Holds reset two cycles, then releases it with a stray rvalid that must be ignored.
    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        pending.delete(); exp_q.delete(); popped.delete(); granted.delete();
        exp_addr = 32'h0; faulted = 1'b0; redir_req = 1'b0; redir_on_both = 1'b0;
        repeat (2) @(negedge clk);
        rstn        = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
    endtask

    task automatic run_pops(input int n, input int budget, input string tag);
        int c = 0;
        while (popped.size() < n && c < budget) begin
            tick();
            c++;
        end
        n_checks++;
        if (popped.size() < n) begin
            n_errors++;
            $display("FAIL %s_timeout: %0d words consumed, need %0d", tag, popped.size(), n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        gnt_en = 1'b1; rsp_en = 1'b1; ready_q = 1'b0;
        repeat (4) tick();
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if ({imem_req, imem_addr, instr_valid, instr_data, instr_pc, instr_fault} !== {1'b0, 32'h0, 1'b0, 64'h0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_values: req=%b addr=%h valid=%b data=%h pc=%h fault=%b",
                     imem_req, imem_addr, instr_valid, instr_data, instr_pc, instr_fault);
        end
        n_checks++;
        if (w_addr !== WRAP_PC) begin
            n_errors++;
            $display("FAIL reset_addr_param: imem_addr_o=%h expected %h", w_addr, WRAP_PC);
        end
    endtask

    task automatic test_in_order();
        int first = -1;
        do_reset();
        gnt_en = 1'b1; rsp_en = 1'b1; ready_q = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (instr_valid && first < 0) first = i;
        end
        n_checks++;
        if (first !== 3) begin
            n_errors++;
            $display("FAIL first_latency: first valid after %0d cycles, expected 3", first);
        end
        run_pops(4, 30, "in_order");
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (pop_at(k) !== 32'(4 * k)) begin
                n_errors++;
                $display("FAIL in_order_pc%0d: got %h expected %h", k, pop_at(k), 32'(4 * k));
            end
        end
    endtask

    task automatic test_backpressure();
        int c = 0;
        do_reset();
        gnt_en = 1'b1; rsp_en = 1'b1; ready_q = 1'b0;
        repeat (8) tick();
        n_checks++;
        if (granted.size() !== 2 || imem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL full_stall: %0d grants, req=%b; expected 2 grants, req=0", granted.size(), imem_req);
        end
        n_checks++;
        if (instr_pc !== 32'h0) begin
            n_errors++;
            $display("FAIL full_head: instr_pc_o=%h expected 0", instr_pc);
        end
        ready_q = 1'b1;
        run_pops(2, 20, "bp_drain");
        while (granted.size() < 3 && c < 20) begin tick(); c++; end
        n_checks++;
        if (pop_at(0) !== 32'h0 || pop_at(1) !== 32'h4) begin
            n_errors++;
            $display("FAIL bp_order: popped %h,%h expected 0,4", pop_at(0), pop_at(1));
        end
        n_checks++;
        if (granted.size() < 3 || granted[2] !== 32'h8) begin
            n_errors++;
            $display("FAIL bp_resume: grants=%0d, third address not 8", granted.size());
        end
    endtask

    task automatic test_redirect_flush();
        do_reset();
        gnt_en = 1'b1; rsp_en = 1'b0; ready_q = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (granted.size() !== 2) begin
            n_errors++;
            $display("FAIL flush_setup: %0d grants outstanding, expected 2", granted.size());
        end
        redir_req = 1'b1; redir_addr = 32'h100;
        tick();
        popped.delete();
        rsp_en = 1'b1;
        run_pops(2, 30, "flush");
        n_checks++;
        if (pop_at(0) !== 32'h100 || pop_at(1) !== 32'h104) begin
            n_errors++;
            $display("FAIL flush_target: popped %h,%h expected 100,104", pop_at(0), pop_at(1));
        end
    endtask

    task automatic test_redirect_collision();
        int c = 0;
        do_reset();
        gnt_en = 1'b1; rsp_en = 1'b1; ready_q = 1'b1;
        redir_addr = 32'h200; both_hit = 1'b0; redir_on_both = 1'b1;
        while (!both_hit && c < 10) begin tick(); c++; end
        redir_on_both = 1'b0;
        popped.delete();
        n_checks++;
        if (!both_hit) begin
            n_errors++;
            $display("FAIL collision_setup: no cycle with gnt and rvalid together within 10 cycles");
        end
        run_pops(2, 30, "collision");
        n_checks++;
        if (pop_at(0) !== 32'h200 || pop_at(1) !== 32'h204) begin
            n_errors++;
            $display("FAIL collision_target: popped %h,%h expected 200,204", pop_at(0), pop_at(1));
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        gnt_en = 1'b1; rsp_en = 1'b1; ready_q = 1'b1;
        repeat (2) tick();
        redir_req = 1'b1; redir_addr = 32'h300;
        tick();
        redir_req = 1'b1; redir_addr = 32'h400;
        tick();
        popped.delete();
        run_pops(2, 30, "b2b");
        n_checks++;
        if (pop_at(0) !== 32'h400 || pop_at(1) !== 32'h404) begin
            n_errors++;
            $display("FAIL b2b_target: popped %h,%h expected 400,404", pop_at(0), pop_at(1));
        end
    endtask

    task automatic test_wrap();
        do_reset();
        gnt_en = 1'b1; rsp_en = 1'b1; ready_q = 1'b1;
        tick();
        n_checks++;
        if (w_req !== 1'b1 || w_addr !== WRAP_PC) begin
            n_errors++;
            $display("FAIL wrap_first: req=%b addr=%h expected 1 and %h", w_req, w_addr, WRAP_PC);
        end
        tick();
        n_checks++;
        if (w_addr !== 32'h0) begin
            n_errors++;
            $display("FAIL wrap_next: imem_addr_o=%h expected 00000000", w_addr);
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        gnt_en = 1'b1; rsp_en = 1'b1; ready_q = 1'b1;
        repeat (4) tick();
        redir_req = 1'b1; redir_addr = 32'h102;
        tick();
        popped.delete();
        repeat (6) tick();
        if (ALIGN_EN) begin
            n_checks++;
            if ({instr_fault, imem_req, instr_valid} !== 3'b100 || imem_addr !== 32'h100) begin
                n_errors++;
                $display("FAIL align_fault: fault=%b req=%b valid=%b addr=%h expected 1,0,0,100",
                         instr_fault, imem_req, instr_valid, imem_addr);
            end
            redir_req = 1'b1; redir_addr = 32'h104;
            tick();
            n_checks++;
            if (instr_fault !== 1'b0) begin
                n_errors++;
                $display("FAIL align_clear: instr_fault_o=%b expected 0", instr_fault);
            end
            popped.delete();
            run_pops(1, 30, "align_resume");
            n_checks++;
            if (pop_at(0) !== 32'h104) begin
                n_errors++;
                $display("FAIL align_resume_pc: popped %h expected 104", pop_at(0));
            end
        end else begin
            run_pops(1, 30, "unaligned");
            n_checks++;
            if (instr_fault !== 1'b0 || pop_at(0) !== 32'h100) begin
                n_errors++;
                $display("FAIL unaligned_ignored: fault=%b popped %h expected 0 and 100",
                         instr_fault, pop_at(0));
            end
        end
    endtask

    task automatic test_random();
        int consumed = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            gnt_en  = ($urandom_range(0, 3) != 0);
            rsp_en  = ($urandom_range(0, 2) != 0);
            ready_q = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 39) == 0) begin
                redir_req  = 1'b1;
                redir_addr = $urandom() & 32'h0000_FFFC;
            end
            tick();
            consumed += popped.size();
            popped.delete();
        end
        gnt_en = 1'b0; rsp_en = 1'b1; ready_q = 1'b1;
        repeat (20) tick();
        consumed += popped.size();
        n_checks++;
        if (exp_q.size() != 0 || pending.size() != 0 || consumed < 50) begin
            n_errors++;
            $display("FAIL random_drain: left fifo=%0d outstanding=%0d, consumed %0d (need >= 50)",
                     exp_q.size(), pending.size(), consumed);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; redir_addr = '0;
        gnt_en = 1'b0; rsp_en = 1'b0; ready_q = 1'b0;
        redir_req = 1'b0; redir_on_both = 1'b0; both_hit = 1'b0; faulted = 1'b0;
        exp_addr = '0;
        test_reset();
        test_in_order();
        test_backpressure();
        test_redirect_flush();
        test_redirect_collision();
        test_back_to_back();
        test_wrap();
        test_misaligned();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
